// File: rtl/hubris_pkg.sv
// Shared core definitions: register-address width, ALU command encodings and
// the register-match helper used by the issue-stage hazard logic.
package hubris_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_CMD_W  = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [ALU_CMD_W-1:0]  alu_cmd_t;

    localparam alu_cmd_t ALU_ADD  = 4'b0000;
    localparam alu_cmd_t ALU_SUB  = 4'b0001;
    localparam alu_cmd_t ALU_SLT  = 4'b0010;
    localparam alu_cmd_t ALU_SLTU = 4'b0011;
    localparam alu_cmd_t ALU_AND  = 4'b0100;
    localparam alu_cmd_t ALU_OR   = 4'b0101;
    localparam alu_cmd_t ALU_XOR  = 4'b0110;
    localparam alu_cmd_t ALU_SLL  = 4'b0111;
    localparam alu_cmd_t ALU_SRL  = 4'b1000;
    localparam alu_cmd_t ALU_SRA  = 4'b1001;

    // x0 is hard-wired zero, so it never matches a producer.
    function automatic logic addr_hit(input reg_addr_t src, input reg_addr_t dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority operand select for one source register: EX result, then WB data,
// then the register-file read data.
module fwd_mux
    import hubris_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [REG_WIDTH-1:0]  id_data,
    input  logic                  ex_fwd_en,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_WIDTH-1:0]  ex_data,
    input  logic                  wb_fwd_en,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [REG_WIDTH-1:0]  wb_data,
    output logic [REG_WIDTH-1:0]  fwd_data
);

    always_comb begin
        // NOTE: default assignment first so every path drives fwd_data and no latch is inferred.
        fwd_data = id_data;
        if (ex_fwd_en && addr_hit(src_addr, ex_rd_addr)) begin
            fwd_data = ex_data;
        end else if (wb_fwd_en && addr_hit(src_addr, wb_rd_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry ID->EX issue register with operand forwarding and hazard stall.
// Define ALU_FWD_EN for EX/WB forwarding; otherwise any RAW match stalls.
module alu_issue_stage
    import hubris_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_WIDTH-1:0]  id_rs1_data,
    input  logic [REG_WIDTH-1:0]  id_rs2_data,
    input  logic [REG_WIDTH-1:0]  id_imm,
    input  logic                  id_use_imm,
    input  logic [ALU_CMD_W-1:0]  id_alu_cmd,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_is_load,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [REG_WIDTH-1:0]  ex_rs1,
    output logic [REG_WIDTH-1:0]  ex_rs2,
    output logic [ALU_CMD_W-1:0]  ex_alu_cmd,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_is_load,
    input  logic [REG_WIDTH-1:0]  alu_out,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [REG_WIDTH-1:0]  wb_rd_data
);

    logic                 rs2_used;
    logic                 ex_hit;
    logic                 stall;
    logic                 accept;
    logic                 ex_fwd_en;
    logic                 wb_fwd_en;
    logic [REG_WIDTH-1:0] rs1_fwd;
    logic [REG_WIDTH-1:0] rs2_fwd;

    assign rs2_used = !id_use_imm;
    assign ex_hit   = ex_valid && (addr_hit(id_rs1_addr, ex_rd_addr) ||
                                   (rs2_used && addr_hit(id_rs2_addr, ex_rd_addr)));

`ifdef ALU_FWD_EN
    // Only a load in EX has no result yet; everything else is forwarded.
    assign stall     = ex_hit && ex_is_load;
    assign ex_fwd_en = ex_valid && !ex_is_load;
    assign wb_fwd_en = 1'b1;
`else
    logic wb_hit;
    assign wb_hit    = addr_hit(id_rs1_addr, wb_rd_addr) ||
                       (rs2_used && addr_hit(id_rs2_addr, wb_rd_addr));
    assign stall     = ex_hit || wb_hit;
    assign ex_fwd_en = 1'b0;
    assign wb_fwd_en = 1'b0;
`endif

    assign id_ready = !stall && (!ex_valid || ex_ready);
    assign accept   = id_valid && id_ready;

    fwd_mux #(.REG_WIDTH(REG_WIDTH)) u_rs1_mux (
        .src_addr   (id_rs1_addr),
        .id_data    (id_rs1_data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd_addr (ex_rd_addr),
        .ex_data    (alu_out),
        .wb_fwd_en  (wb_fwd_en),
        .wb_rd_addr (wb_rd_addr),
        .wb_data    (wb_rd_data),
        .fwd_data   (rs1_fwd)
    );

    fwd_mux #(.REG_WIDTH(REG_WIDTH)) u_rs2_mux (
        .src_addr   (id_rs2_addr),
        .id_data    (id_rs2_data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd_addr (ex_rd_addr),
        .ex_data    (alu_out),
        .wb_fwd_en  (wb_fwd_en),
        .wb_rd_addr (wb_rd_addr),
        .wb_data    (wb_rd_data),
        .fwd_data   (rs2_fwd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // NOTE: payload registers are reset too because their reset values are architecturally visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_alu_cmd <= ALU_ADD;
            ex_rd_addr <= '0;
            ex_is_load <= 1'b0;
        end else if (accept && !flush) begin
            ex_rs1     <= rs1_fwd;
            ex_rs2     <= id_use_imm ? id_imm : rs2_fwd;
            ex_alu_cmd <= id_alu_cmd;
            ex_rd_addr <= id_rd_addr;
            ex_is_load <= id_is_load;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: reset, vector table, directed
// pipeline sequences and randomized traffic against a behavioural model.
module tb_alu_issue_stage;
    import hubris_pkg::*;

`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic        id_use_imm = 1'b0, id_is_load = 1'b0;
    logic [3:0]  id_alu_cmd = '0;
    logic        ex_valid, ex_is_load;
    logic        ex_ready = 1'b1;
    logic [31:0] ex_rs1, ex_rs2;
    logic [3:0]  ex_alu_cmd;
    logic [4:0]  ex_rd_addr;
    logic [31:0] alu_out = '0, wb_rd_data = '0;
    logic [4:0]  wb_rd_addr = '0;

    int total = 0;
    int bad = 0;

    alu_issue_stage #(.REG_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_cmd(id_alu_cmd),
        .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_alu_cmd(ex_alu_cmd),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .alu_out(alu_out), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                            input logic [4:0] a2, input logic [31:0] d2,
                            input logic [31:0] imm, input logic ui,
                            input logic [3:0] cmd, input logic [4:0] rd, input logic ld);
        id_valid = v; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
        id_imm = imm; id_use_imm = ui; id_alu_cmd = cmd; id_rd_addr = rd; id_is_load = ld;
    endtask

    task automatic idle();
        drive_id(1'b0, '0, '0, '0, '0, '0, 1'b0, ALU_ADD, '0, 1'b0);
        ex_ready = 1'b1; flush = 1'b0; wb_rd_addr = '0;
    endtask

    // Behavioural view of the EX slot: what instruction sits there, if any.
    logic        m_valid = 1'b0, m_load = 1'b0;
    logic [31:0] m_rs1 = '0, m_rs2 = '0;
    logic [3:0]  m_cmd = '0;
    logic [4:0]  m_rd = '0;

    function automatic bit reads(input logic [4:0] src, input logic [4:0] producer);
        return (src != 0) && (src == producer);
    endfunction

    function automatic bit model_stall();
        bit on_ex, on_wb;
        on_ex = m_valid && (reads(id_rs1_addr, m_rd) || (!id_use_imm && reads(id_rs2_addr, m_rd)));
        on_wb = reads(id_rs1_addr, wb_rd_addr) || (!id_use_imm && reads(id_rs2_addr, wb_rd_addr));
        return FWD ? (on_ex && m_load) : (on_ex || on_wb);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf);
        if (FWD && m_valid && !m_load && reads(src, m_rd)) return alu_out;
        if (FWD && reads(src, wb_rd_addr)) return wb_rd_data;
        return rf;
    endfunction

    typedef struct {
        logic [4:0]  ex_rd;
        logic        ex_load;
        logic [4:0]  wb_rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        use_imm;
        logic        rdy_f;
        logic [31:0] rs1_f;
        logic [31:0] rs2_f;
        logic        rdy_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'd5, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 32'd7,     32'd7,      1'b0};
        vecs[1] = '{5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h11,    32'h22,     1'b1};
        vecs[2] = '{5'd3, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0,     32'h0,      1'b0};
        vecs[3] = '{5'd3, 1'b1, 5'd0, 5'd4, 5'd3, 1'b1, 1'b1, 32'h11,    32'h100,    1'b1};
        vecs[4] = '{5'd2, 1'b0, 5'd6, 5'd6, 5'd2, 1'b0, 1'b1, 32'd9,     32'd7,      1'b0};
        vecs[5] = '{5'd2, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0,     32'h0,      1'b0};
        vecs[6] = '{5'd1, 1'b0, 5'd0, 5'd4, 5'd5, 1'b0, 1'b1, 32'h11,    32'h22,     1'b1};
        vecs[7] = '{5'd3, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 32'h11,    32'h22,     1'b1};

        // Reset values appear without any clock edge.
        #1;
        check("rst ex_valid", ex_valid, 0);
        check("rst ex_rs1", ex_rs1, 0);
        check("rst ex_rs2", ex_rs2, 0);
        check("rst ex_alu_cmd", ex_alu_cmd, ALU_ADD);
        check("rst ex_rd_addr", ex_rd_addr, 0);
        check("rst ex_is_load", ex_is_load, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst id_ready", id_ready, 1);
        tick();

        // Vector table: preload an EX entry, then present a dependent instruction.
        for (int i = 0; i < 8; i++) begin
            bit rdy;
            logic [31:0] e1, e2;
            drive_id(1'b1, '0, '0, '0, '0, '0, 1'b0, ALU_ADD, vecs[i].ex_rd, vecs[i].ex_load);
            ex_ready = 1'b0; wb_rd_addr = '0;
            tick();
            drive_id(1'b1, vecs[i].a1, 32'h11, vecs[i].a2, 32'h22, 32'h100, vecs[i].use_imm,
                     ALU_OR, 5'd9, 1'b0);
            ex_ready = 1'b1; alu_out = 32'd7; wb_rd_addr = vecs[i].wb_rd; wb_rd_data = 32'd9;
            rdy = FWD ? vecs[i].rdy_f : vecs[i].rdy_n;
            e1  = FWD ? vecs[i].rs1_f : 32'h11;
            e2  = FWD ? vecs[i].rs2_f : (vecs[i].use_imm ? 32'h100 : 32'h22);
            #3;
            check($sformatf("vec%0d id_ready", i), id_ready, rdy);
            tick();
            check($sformatf("vec%0d ex_valid", i), ex_valid, rdy);
            if (rdy) begin
                check($sformatf("vec%0d ex_rs1", i), ex_rs1, e1);
                check($sformatf("vec%0d ex_rs2", i), ex_rs2, e2);
            end
            idle();
            tick();
        end

        // Back-to-back dependent pair: addi x1,x0,5 ; add x2,x1,x1.
        drive_id(1'b1, 5'd0, '0, 5'd0, '0, 32'd5, 1'b1, ALU_ADD, 5'd1, 1'b0);
        tick();
        check("b2b first ex_rs2", ex_rs2, 5);
        drive_id(1'b1, 5'd1, '0, 5'd1, '0, '0, 1'b0, ALU_ADD, 5'd2, 1'b0);
        alu_out = 32'd5;
        #3;
        check("b2b id_ready", id_ready, FWD ? 1 : 0);
        tick();
        check("b2b ex_valid", ex_valid, FWD ? 1 : 0);
        check("b2b ex_rs1", ex_rs1, FWD ? 5 : 0);
        check("b2b ex_rs2", ex_rs2, 5);
        check("b2b ex_rd_addr", ex_rd_addr, FWD ? 2 : 1);
        idle(); tick(); tick();

        // Load-use: lw x3 then a consumer of x3.
        drive_id(1'b1, 5'd0, '0, 5'd0, '0, 32'h40, 1'b1, ALU_ADD, 5'd3, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 32'h1234, 5'd0, '0, 32'd4, 1'b1, ALU_ADD, 5'd4, 1'b0);
        #3;
        check("ldu stall id_ready", id_ready, 0);
        tick();
        check("ldu bubble ex_valid", ex_valid, 0);
        wb_rd_addr = 5'd3; wb_rd_data = 32'hDEADBEEF;
        #3;
        check("ldu wb id_ready", id_ready, FWD ? 1 : 0);
        tick();
        check("ldu ex_valid", ex_valid, FWD ? 1 : 0);
        check("ldu ex_rs1", ex_rs1, FWD ? 32'hDEADBEEF : 32'h0);
        idle(); tick(); tick();

        // Backpressure: entry A held for three cycles, then B follows.
        drive_id(1'b1, 5'd4, 32'hA1, 5'd5, 32'hA2, '0, 1'b0, ALU_SUB, 5'd7, 1'b0);
        ex_ready = 1'b0;
        tick();
        drive_id(1'b1, 5'd6, 32'hB1, 5'd0, 32'hB2, 32'h33, 1'b1, ALU_XOR, 5'd8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #3;
            check("bp id_ready", id_ready, 0);
            tick();
            check("bp ex_valid", ex_valid, 1);
            check("bp ex_rs1", ex_rs1, 32'hA1);
            check("bp ex_rs2", ex_rs2, 32'hA2);
            check("bp ex_alu_cmd", ex_alu_cmd, ALU_SUB);
            check("bp ex_rd_addr", ex_rd_addr, 7);
        end
        ex_ready = 1'b1;
        #3;
        check("bp drain id_ready", id_ready, 1);
        tick();
        check("bp next ex_rs1", ex_rs1, 32'hB1);
        check("bp next ex_rs2", ex_rs2, 32'h33);
        check("bp next ex_alu_cmd", ex_alu_cmd, ALU_XOR);
        check("bp next ex_rd_addr", ex_rd_addr, 8);
        idle(); tick();

        // Flush beats a same-cycle acceptance.
        drive_id(1'b1, 5'd0, '0, 5'd0, '0, 32'd1, 1'b1, ALU_AND, 5'd9, 1'b0);
        tick();
        check("flush pre ex_valid", ex_valid, 1);
        flush = 1'b1;
        tick();
        check("flush ex_valid", ex_valid, 0);
        idle(); tick();

        // Randomized traffic against the model.
        m_valid = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            bit exp_rdy, take;
            logic [31:0] n1, n2;
            id_valid    = ($urandom_range(0, 4) != 0);
            id_rs1_addr = 5'($urandom_range(0, 3));
            id_rs2_addr = 5'($urandom_range(0, 3));
            id_rd_addr  = 5'($urandom_range(0, 3));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_use_imm  = ($urandom_range(0, 2) == 0);
            id_alu_cmd  = 4'($urandom_range(0, 9));
            id_is_load  = ($urandom_range(0, 3) == 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            alu_out     = $urandom;
            wb_rd_addr  = 5'($urandom_range(0, 3));
            wb_rd_data  = $urandom;
            #3;
            exp_rdy = !model_stall() && (!m_valid || ex_ready);
            check("rnd id_ready", id_ready, exp_rdy);
            take = id_valid && exp_rdy;
            n1 = operand(id_rs1_addr, id_rs1_data);
            n2 = id_use_imm ? id_imm : operand(id_rs2_addr, id_rs2_data);
            if (take && !flush) begin
                m_rs1 = n1; m_rs2 = n2; m_cmd = id_alu_cmd; m_rd = id_rd_addr; m_load = id_is_load;
            end
            if (flush) m_valid = 1'b0;
            else if (take) m_valid = 1'b1;
            else if (ex_ready) m_valid = 1'b0;
            tick();
            check("rnd ex_valid", ex_valid, m_valid);
            if (m_valid) begin
                check("rnd ex_rs1", ex_rs1, m_rs1);
                check("rnd ex_rs2", ex_rs2, m_rs2);
                check("rnd ex_alu_cmd", ex_alu_cmd, m_cmd);
                check("rnd ex_rd_addr", ex_rd_addr, m_rd);
                check("rnd ex_is_load", ex_is_load, m_load);
            end
        end
        idle(); tick();

        // Asynchronous reset while stalled.
        drive_id(1'b1, 5'd4, 32'hC1, 5'd5, 32'hC2, '0, 1'b0, ALU_SRA, 5'd6, 1'b1);
        ex_ready = 1'b0;
        tick();
        tick();
        check("mid pre ex_valid", ex_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst ex_valid", ex_valid, 0);
        check("mid rst ex_rs1", ex_rs1, 0);
        check("mid rst ex_rs2", ex_rs2, 0);
        check("mid rst ex_alu_cmd", ex_alu_cmd, ALU_ADD);
        check("mid rst ex_rd_addr", ex_rd_addr, 0);
        check("mid rst ex_is_load", ex_is_load, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid rel id_ready", id_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
